// File: rtl/sc_compare_timer_pkg.sv
// Shared definitions for the compare timer: FSM state encoding and comparator polarity.
package sc_compare_timer_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'b00,
    STATE_RUN  = 2'b01,
    STATE_DONE = 2'b10
  } timerState_t;

  // Comparator polarity used across the codebase: 0 means the operands are equal.
  localparam logic EQUAL_FLAG = 1'b0;

  function automatic logic mismatchFlag(input logic isEqual);
    return isEqual ? EQUAL_FLAG : ~EQUAL_FLAG;
  endfunction

endpackage

// File: rtl/sc_compare_timer_counter.sv
// Up-counter register with synchronous clear, increment enable and hold.
module sc_compare_timer_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             clear,
  input  logic             increment,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (increment) begin
      count <= count + WIDTH'(1'b1);
    end
  end

endmodule

// File: rtl/sc_compare_timer.sv
// Loadable match timer: captures a target on start, counts from zero, pulses match on equality.
module sc_compare_timer
  import sc_compare_timer_pkg::*;
#(
  parameter int unsigned NUMBER_DATAWIDTH = 8
) (
  input  logic                        SC_COMPARETIMER_CLOCK_50,
  input  logic                        SC_COMPARETIMER_RESET_InLow,
  input  logic                        SC_COMPARETIMER_start_In,
  input  logic                        SC_COMPARETIMER_stop_In,
  input  logic [NUMBER_DATAWIDTH-1:0] SC_COMPARETIMER_target_InBUS,
  output logic [NUMBER_DATAWIDTH-1:0] SC_COMPARETIMER_count_OutBUS,
  output logic                        SC_COMPARETIMER_busy_Out,
  output logic                        SC_COMPARETIMER_match_Out,
  output logic                        SC_COMPARETIMER_notequal_Out
);

  timerState_t                 state;
  timerState_t                 stateNext;
  logic [NUMBER_DATAWIDTH-1:0] targetReg;
  logic [NUMBER_DATAWIDTH-1:0] countReg;
  logic                        loadTarget;
  logic                        clearCount;
  logic                        incrementCount;
  logic                        isEqual;

  assign isEqual = (countReg == targetReg);

  always_ff @(posedge SC_COMPARETIMER_CLOCK_50 or negedge SC_COMPARETIMER_RESET_InLow) begin
    if (!SC_COMPARETIMER_RESET_InLow) begin
      state     <= STATE_IDLE;
      targetReg <= '0;
    end else begin
      state <= stateNext;
      if (loadTarget) begin
        targetReg <= SC_COMPARETIMER_target_InBUS;
      end
    end
  end

  // In RUN, stop beats match beats increment; comparing before incrementing prevents wrap.
  always_comb begin
    stateNext      = state;
    loadTarget     = 1'b0;
    clearCount     = 1'b0;
    incrementCount = 1'b0;
    case (state)
      STATE_IDLE: begin
        if (SC_COMPARETIMER_start_In) begin
          loadTarget = 1'b1;
          clearCount = 1'b1;
          stateNext  = STATE_RUN;
        end
      end
      STATE_RUN: begin
        if (SC_COMPARETIMER_stop_In) begin
          stateNext = STATE_IDLE;
        end else if (isEqual) begin
          stateNext = STATE_DONE;
        end else begin
          incrementCount = 1'b1;
        end
      end
      STATE_DONE: stateNext = STATE_IDLE;
      default:    stateNext = STATE_IDLE;
    endcase
  end

  sc_compare_timer_counter #(
    .WIDTH(NUMBER_DATAWIDTH)
  ) u_counter (
    .clk       (SC_COMPARETIMER_CLOCK_50),
    .rstN      (SC_COMPARETIMER_RESET_InLow),
    .clear     (clearCount),
    .increment (incrementCount),
    .count     (countReg)
  );

  assign SC_COMPARETIMER_count_OutBUS = countReg;
  assign SC_COMPARETIMER_busy_Out     = (state == STATE_RUN);
  assign SC_COMPARETIMER_match_Out    = (state == STATE_DONE);
  assign SC_COMPARETIMER_notequal_Out = mismatchFlag(isEqual);

endmodule

// File: tb/tb_sc_compare_timer.sv
// Self-checking bench for sc_compare_timer: vector table, corner sequences, random vs reference model.
module tb_sc_compare_timer;

  logic       clk;
  logic       rstN;
  logic       start;
  logic       stop;
  logic [7:0] target;
  logic [7:0] dutCount;
  logic       dutBusy;
  logic       dutMatch;
  logic       dutNe;

  int passed = 0;
  int total  = 0;

  // Reference model: running flag, one-cycle done flag, count and captured target.
  bit mRun;
  bit mDone;
  int mCnt;
  int mTgt;

  typedef struct {
    logic       start;
    logic       stop;
    logic [7:0] target;
    logic [7:0] expCount;
    logic       expBusy;
    logic       expMatch;
    logic       expNe;
  } vec_t;

  vec_t vecs[$];

  sc_compare_timer #(
    .NUMBER_DATAWIDTH(8)
  ) dut (
    .SC_COMPARETIMER_CLOCK_50     (clk),
    .SC_COMPARETIMER_RESET_InLow  (rstN),
    .SC_COMPARETIMER_start_In     (start),
    .SC_COMPARETIMER_stop_In      (stop),
    .SC_COMPARETIMER_target_InBUS (target),
    .SC_COMPARETIMER_count_OutBUS (dutCount),
    .SC_COMPARETIMER_busy_Out     (dutBusy),
    .SC_COMPARETIMER_match_Out    (dutMatch),
    .SC_COMPARETIMER_notequal_Out (dutNe)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic modelReset();
    mRun  = 0;
    mDone = 0;
    mCnt  = 0;
    mTgt  = 0;
  endtask

  task automatic modelEdge();
    if (mRun) begin
      if (stop) mRun = 0;
      else if (mCnt == mTgt) begin
        mRun  = 0;
        mDone = 1;
      end else mCnt = mCnt + 1;
    end else if (mDone) begin
      mDone = 0;
    end else if (start) begin
      mTgt = int'(target);
      mCnt = 0;
      mRun = 1;
    end
  endtask

  task automatic checkModel(input string tag);
    check({tag, ".count"}, int'(dutCount), mCnt);
    check({tag, ".busy"}, int'(dutBusy), int'(mRun));
    check({tag, ".match"}, int'(dutMatch), int'(mDone));
    check({tag, ".notequal"}, int'(dutNe), (mCnt != mTgt) ? 1 : 0);
  endtask

  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic p, input logic [7:0] t);
    start  = s;
    stop   = p;
    target = t;
  endtask

  initial begin
    int lastMatch;
    int pulses;

    rstN = 1'b0;
    drive(1'b0, 1'b0, 8'd0);
    modelReset();
    #1;
    check("reset.count", int'(dutCount), 0);
    check("reset.busy", int'(dutBusy), 0);
    check("reset.match", int'(dutMatch), 0);
    check("reset.notequal", int'(dutNe), 0);
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b1;

    // Vector table: target 5 run, target 10 abort at count 4, stop in IDLE, target 3 run.
    vecs.push_back('{1'b1, 1'b0, 8'd5, 8'd0, 1'b1, 1'b0, 1'b1});
    for (int i = 1; i <= 4; i++) vecs.push_back('{1'b0, 1'b0, 8'd5, 8'(i), 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 8'd5, 8'd5, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'd5, 8'd5, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'd5, 8'd5, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 8'd10, 8'd0, 1'b1, 1'b0, 1'b1});
    for (int i = 1; i <= 4; i++) vecs.push_back('{1'b0, 1'b0, 8'd10, 8'(i), 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'd10, 8'd4, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'd10, 8'd4, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 8'd3, 8'd0, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 8'd3, 8'd1, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 8'd3, 8'd2, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 8'd3, 8'd3, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'd3, 8'd3, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'd3, 8'd3, 1'b0, 1'b0, 1'b0});

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].stop, vecs[i].target);
      tick();
      check($sformatf("vec%0d.count", i), int'(dutCount), int'(vecs[i].expCount));
      check($sformatf("vec%0d.busy", i), int'(dutBusy), int'(vecs[i].expBusy));
      check($sformatf("vec%0d.match", i), int'(dutMatch), int'(vecs[i].expMatch));
      check($sformatf("vec%0d.notequal", i), int'(dutNe), int'(vecs[i].expNe));
    end

    // Target 0: match right after the first counting edge.
    drive(1'b1, 1'b0, 8'd0);
    tick();
    check("t0.busy", int'(dutBusy), 1);
    check("t0.notequal", int'(dutNe), 0);
    drive(1'b0, 1'b0, 8'd0);
    tick();
    check("t0.match", int'(dutMatch), 1);
    check("t0.count", int'(dutCount), 0);
    tick();
    checkModel("t0.idle");

    // Target 255: reaches all-ones and matches without wrapping.
    drive(1'b1, 1'b0, 8'd255);
    tick();
    drive(1'b0, 1'b0, 8'd0);
    for (int i = 1; i <= 255; i++) begin
      tick();
      checkModel("t255");
    end
    check("t255.busyBeforeMatch", int'(dutBusy), 1);
    tick();
    check("t255.match", int'(dutMatch), 1);
    check("t255.count", int'(dutCount), 255);
    tick();
    check("t255.holdCount", int'(dutCount), 255);

    // Ignored inputs in RUN: a second start and a changed target do not disturb target 6.
    drive(1'b1, 1'b0, 8'd6);
    tick();
    drive(1'b0, 1'b0, 8'd6);
    tick();
    tick();
    drive(1'b1, 1'b0, 8'd2);
    tick();
    drive(1'b0, 1'b0, 8'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkModel("ign");
    end
    check("ign.busyAtE6", int'(dutBusy), 1);
    check("ign.countAtE6", int'(dutCount), 6);
    tick();
    check("ign.match", int'(dutMatch), 1);
    check("ign.count", int'(dutCount), 6);
    check("ign.notequal", int'(dutNe), 0);
    tick();

    // Asynchronous reset mid-RUN at count 3, asserted between clock edges.
    drive(1'b1, 1'b0, 8'd10);
    tick();
    drive(1'b0, 1'b0, 8'd10);
    repeat (3) tick();
    check("midrun.countBefore", int'(dutCount), 3);
    #2;
    rstN = 1'b0;
    modelReset();
    #1;
    check("asyncRst.count", int'(dutCount), 0);
    check("asyncRst.busy", int'(dutBusy), 0);
    check("asyncRst.match", int'(dutMatch), 0);
    check("asyncRst.notequal", int'(dutNe), 0);
    @(posedge clk);
    #1;
    checkModel("inRst");
    rstN = 1'b1;
    tick();
    checkModel("afterRst");

    // Start held high with target 1: DONE repeats every 4 cycles.
    drive(1'b1, 1'b0, 8'd1);
    lastMatch = -1;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      checkModel("held");
      if (dutMatch) begin
        if (lastMatch >= 0) check("held.period", i - lastMatch, 4);
        lastMatch = i;
        pulses++;
      end
    end
    check("held.pulses", pulses, 4);
    drive(1'b0, 1'b0, 8'd0);
    repeat (4) tick();

    // Random stimulus against the reference model.
    for (int i = 0; i < 2000; i++) begin
      start = ($urandom_range(0, 2) == 0);
      stop  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) target = 8'($urandom);
      else target = 8'($urandom_range(0, 12));
      tick();
      checkModel("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
